// File: rtl/lc3_wb_pkg.sv
// lc3_wb_pkg: shared widths and entry type for the LC-3 register-file writeback path
package lc3_wb_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  typedef struct packed {
    logic [REG_AW-1:0] dr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of pending writes, exposing entries oldest-first with a valid mask
module wb_fifo
  import lc3_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                ents [DEPTH],
  output logic [DEPTH-1:0]         valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW:0] rd_ptr, wr_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  // Slot g is the g-th oldest entry; index arithmetic wraps because DEPTH is a power of two
  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign ents[g]  = mem[AW'(rd_ptr[AW-1:0] + AW'(g))];
    assign valid[g] = (AW+1)'(g) < count;
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers register writes, retires one per clock and forwards pending values to decode
module reg_writeback_queue
  import lc3_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [REG_AW-1:0]      wb_dr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   hold,
  output logic                   LD_REG,
  output logic [REG_AW-1:0]      DR,
  output logic [DATA_W-1:0]      Data_In,
  input  logic [REG_AW-1:0]      SR1,
  input  logic [REG_AW-1:0]      SR2,
  output logic                   SR1_hit,
  output logic [DATA_W-1:0]      SR1_fwd,
  output logic                   SR2_hit,
  output logic [DATA_W-1:0]      SR2_fwd,
  output logic [$clog2(DEPTH):0] count
);
  wb_entry_t ents [DEPTH];
  logic [DEPTH-1:0] valid;
  logic full, empty;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk(Clk), .Reset_n(Reset_n),
    .push(wb_valid & wb_ready), .pop(LD_REG),
    .din('{dr: wb_dr, data: wb_data}),
    .ents(ents), .valid(valid), .count(count), .full(full), .empty(empty)
  );
  assign wb_ready = !full;
  assign LD_REG   = !empty & !hold;
  assign DR       = LD_REG ? ents[0].dr : '0;
  assign Data_In  = LD_REG ? ents[0].data : '0;
  // Scan oldest to youngest so the last match wins
  always_comb begin
    SR1_hit = 1'b0;
    SR1_fwd = '0;
    SR2_hit = 1'b0;
    SR2_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && ents[i].dr == SR1) begin
        SR1_hit = 1'b1;
        SR1_fwd = ents[i].data;
      end
      if (valid[i] && ents[i].dr == SR2) begin
        SR2_hit = 1'b1;
        SR2_fwd = ents[i].data;
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;
  logic Clk = 0, Reset_n = 0;
  logic wb_valid = 0, wb_ready, hold = 0, LD_REG, SR1_hit, SR2_hit;
  logic [2:0] wb_dr = 0, DR, SR1 = 0, SR2 = 0;
  logic [15:0] wb_data = 0, Data_In, SR1_fwd, SR2_fwd;
  logic [2:0] count;
  int errors = 0, checks = 0;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dr(wb_dr), .wb_data(wb_data), .hold(hold), .LD_REG(LD_REG), .DR(DR),
    .Data_In(Data_In), .SR1(SR1), .SR2(SR2), .SR1_hit(SR1_hit), .SR1_fwd(SR1_fwd),
    .SR2_hit(SR2_hit), .SR2_fwd(SR2_fwd), .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_count", count, 0);
    check("rst_ld", LD_REG, 0);
    check("rst_dr", DR, 0);
    check("rst_data", Data_In, 0);
    check("rst_hit1", SR1_hit, 0);
    check("rst_fwd1", SR1_fwd, 0);
    #7 Reset_n = 1;
    step();
    check("rst_ready", wb_ready, 1);

    // single write R3=0x1234
    wb_valid = 1; wb_dr = 3; wb_data = 16'h1234; SR1 = 3;
    #1;
    check("single_no_pass", LD_REG, 0);
    check("single_no_fwd", SR1_hit, 0);
    step();
    wb_valid = 0;
    #1;
    check("single_ld", LD_REG, 1);
    check("single_dr", DR, 3);
    check("single_data", Data_In, 16'h1234);
    check("single_count1", count, 1);
    check("single_fwd_hit", SR1_hit, 1);
    check("single_fwd", SR1_fwd, 16'h1234);
    step();
    check("single_count0", count, 0);
    check("single_ld0", LD_REG, 0);
    check("single_dr0", DR, 0);

    // fill with hold, then drain in order
    hold = 1; wb_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wb_dr = 3'(i); wb_data = 16'hA000 + 16'(i);
      step();
    end
    check("fill_count", count, 4);
    check("fill_ready", wb_ready, 0);
    check("fill_hold_ld", LD_REG, 0);
    wb_dr = 7; wb_data = 16'hDEAD; SR2 = 7;
    step();
    check("fill_5th_count", count, 4);
    check("fill_5th_nofwd", SR2_hit, 0);
    wb_valid = 0; hold = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_ld", LD_REG, 1);
      check("drain_dr", DR, i);
      check("drain_data", Data_In, 16'hA000 + i);
      step();
    end
    check("drain_empty", count, 0);
    check("drain_ld0", LD_REG, 0);

    // youngest match forwarded
    hold = 1; wb_valid = 1; wb_dr = 5; wb_data = 16'h0001;
    step();
    wb_data = 16'h00FF;
    step();
    wb_valid = 0; SR1 = 5; SR2 = 6;
    #1;
    check("young_hit1", SR1_hit, 1);
    check("young_fwd1", SR1_fwd, 16'h00FF);
    check("young_hit2", SR2_hit, 0);
    check("young_fwd2", SR2_fwd, 0);
    hold = 0;
    #1;
    check("young_head_dr", DR, 5);
    check("young_head_data", Data_In, 16'h0001);
    check("young_head_fwd", SR1_fwd, 16'h00FF);
    step();
    check("young_2nd_data", Data_In, 16'h00FF);
    step();
    check("young_empty", count, 0);

    // push and pop together at count=2, wrapping the pointers
    hold = 1; wb_valid = 1;
    for (int j = 0; j < 2; j++) begin
      wb_dr = 3'((j + 1) % 8); wb_data = 16'h0100 + 16'(j);
      step();
    end
    hold = 0;
    for (int k = 0; k < 10; k++) begin
      wb_dr = 3'((k + 3) % 8); wb_data = 16'h0102 + 16'(k);
      #1;
      check("pp_count", count, 2);
      check("pp_dr", DR, (k + 1) % 8);
      check("pp_data", Data_In, 16'h0100 + k);
      step();
    end
    wb_valid = 0;
    #1;
    for (int j = 10; j < 12; j++) begin
      check("pp_tail_data", Data_In, 16'h0100 + j);
      step();
    end
    check("pp_empty", count, 0);

    // request in flight is not forwarded until it lands in the queue
    wb_valid = 1; wb_dr = 2; wb_data = 16'hBEEF; SR1 = 2;
    #1;
    check("sc_hit0", SR1_hit, 0);
    check("sc_fwd0", SR1_fwd, 0);
    step();
    wb_valid = 0;
    #1;
    check("sc_hit1", SR1_hit, 1);
    check("sc_fwd1", SR1_fwd, 16'hBEEF);
    step();

    // async reset with three pending writes
    hold = 1; wb_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wb_dr = 3'(i + 4); wb_data = 16'h5550 + 16'(i);
      step();
    end
    wb_valid = 0; hold = 0; SR1 = 4;
    #1;
    check("mr_count3", count, 3);
    check("mr_ld1", LD_REG, 1);
    #1 Reset_n = 0;
    #1;
    check("mr_count", count, 0);
    check("mr_ld", LD_REG, 0);
    check("mr_dr", DR, 0);
    check("mr_data", Data_In, 0);
    check("mr_hit", SR1_hit, 0);
    #2 Reset_n = 1;
    step();
    check("mr_ready", wb_ready, 1);
    check("mr_count_after", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
